// File: rtl/bus_mailbox_pkg.sv
// Shared definitions for the bus mailbox target: register offsets, bit positions and FSM states.
package bus_mailbox_pkg;

  localparam int OFS_DATA    = 0;
  localparam int OFS_STATUS  = 1;
  localparam int OFS_CONTROL = 2;

  localparam int STAT_FULL  = 7;
  localparam int STAT_EMPTY = 6;
  localparam int STAT_OVF   = 5;
  localparam int STAT_LVL_W = 5;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/bus_mailbox_slave_if.sv
// Local system bus target-slot signals as seen by the mailbox.
interface bus_mailbox_slave_if;
  import bus_mailbox_pkg::*;

  logic [15:0] s_address_in;
  logic        s_address_in_valid;
  logic        s_rw;
  logic [7:0]  s_data_in;
  logic        s_data_in_valid;
  logic [7:0]  s_data_out;
  logic        s_data_out_valid;
  logic        s_ack;
  logic        s_ready;

  modport slave (
    input  s_address_in, s_address_in_valid, s_rw, s_data_in, s_data_in_valid,
    output s_data_out, s_data_out_valid, s_ack, s_ready
  );

  modport master (
    output s_address_in, s_address_in_valid, s_rw, s_data_in, s_data_in_valid,
    input  s_data_out, s_data_out_valid, s_ack, s_ready
  );

endinterface

// File: rtl/bus_mailbox_slave_fifo.sv
// Byte FIFO for the mailbox: push/pop/flush with sticky overflow; full is judged before any pop.
module mailbox_fifo
  import bus_mailbox_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic                     i_clr_ovf,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_ovf     = r_ovf;
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push_ok && !w_pop_ok)      r_level <= r_level + 1'b1;
        else if (!w_push_ok && w_pop_ok) r_level <= r_level - 1'b1;
      end
      // A new overflow outranks a clear landing in the same cycle
      if (i_push && o_full) r_ovf <= 1'b1;
      else if (i_clr_ovf)   r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/bus_mailbox_slave.sv
// Mailbox bus target: register decode, transaction FSM and stream/bus arbitration around mailbox_fifo.
module bus_mailbox_slave
  import bus_mailbox_pkg::*;
#(
  parameter int INTERNAL_ADDR_BITS = 12,
  parameter int DEPTH              = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_mailbox_slave_if.slave   bus,
  output logic [7:0]           pop_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic                 fifo_not_empty
);

  localparam int AB    = INTERNAL_ADDR_BITS;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AB-1:0]   r_offset;
  logic            r_rw;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;

  logic            w_is_data;
  logic            w_is_status;
  logic            w_is_control;
  logic            w_exec_wr;
  logic            w_exec_rd;
  logic            w_push;
  logic            w_bus_pop;
  logic            w_flush;
  logic            w_clr_ovf;
  logic            w_stream_pop;
  logic [7:0]      w_head;
  logic [7:0]      w_status;
  logic [7:0]      w_rd_value;
  logic            w_full;
  logic            w_empty;
  logic            w_ovf;
  logic [LVL_W-1:0] w_level;
  logic            w_unused_addr;

  // Upper address bits were already used by the interconnect to select us
  assign w_unused_addr = ^bus.s_address_in[15:AB];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_exec_rd) r_rdata <= w_rd_value;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.s_address_in_valid) begin
      r_offset <= bus.s_address_in[AB-1:0];
      r_rw     <= bus.s_rw;
    end
    if (bus.s_data_in_valid &&
        ((r_state == ST_IDLE && bus.s_address_in_valid && bus.s_rw) || r_state == ST_WAIT_DATA))
      r_wdata <= bus.s_data_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_address_in_valid) begin
          if (!bus.s_rw || bus.s_data_in_valid) w_state_nxt = ST_EXEC;
          else                                  w_state_nxt = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: if (bus.s_data_in_valid) w_state_nxt = ST_EXEC;
      ST_EXEC:      w_state_nxt = ST_RESP;
      ST_RESP:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_is_data    = (r_offset == AB'(OFS_DATA));
  assign w_is_status  = (r_offset == AB'(OFS_STATUS));
  assign w_is_control = (r_offset == AB'(OFS_CONTROL));
  assign w_exec_wr    = (r_state == ST_EXEC) && r_rw;
  assign w_exec_rd    = (r_state == ST_EXEC) && !r_rw;
  assign w_push       = w_exec_wr && w_is_data;
  assign w_bus_pop    = w_exec_rd && w_is_data;
  assign w_flush      = w_exec_wr && w_is_control && r_wdata[CTRL_FLUSH];
  assign w_clr_ovf    = w_exec_wr && w_is_control && r_wdata[CTRL_CLR_OVF];

  // A bus DATA read owns the head for its EXEC cycle; a flush cycle offers nothing
  assign pop_valid      = !w_empty && !w_bus_pop && !w_flush;
  assign w_stream_pop   = pop_valid && pop_ready;
  assign pop_data       = w_head;
  assign fifo_not_empty = !w_empty;

  always_comb begin
    w_status                   = 8'h00;
    w_status[STAT_FULL]        = w_full;
    w_status[STAT_EMPTY]       = w_empty;
    w_status[STAT_OVF]         = w_ovf;
    w_status[STAT_LVL_W-1:0]   = STAT_LVL_W'(w_level);
  end

  always_comb begin
    w_rd_value = 8'h00;
    if (w_is_data)        w_rd_value = w_head;
    else if (w_is_status) w_rd_value = w_status;
  end

  assign bus.s_ready          = (r_state == ST_IDLE);
  assign bus.s_ack            = (r_state == ST_RESP);
  assign bus.s_data_out_valid = (r_state == ST_RESP) && !r_rw;
  assign bus.s_data_out       = r_rdata;

  mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wdata   (r_wdata),
    .i_pop     (w_bus_pop || w_stream_pop),
    .i_flush   (w_flush),
    .i_clr_ovf (w_clr_ovf),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ovf     (w_ovf),
    .o_level   (w_level)
  );

endmodule
